tdm_demux: RTL and testbench
============================

// Module: tdm_demux
//
// PURPOSE
//   Time-division demultiplexer: the receiving end of a 2^SEL_W:1 TDM mux link.
//   A framed serial word stream arrives one beat at a time. The first beat of each frame is marked by in_sof.
//   Each beat goes to the output channel of its slot, in order: slot 0 -> ch0 ... slot NUM_CH-1 -> ch(NUM_CH-1).
//   Placed after the link mux; reassembles per-channel data for downstream consumers.
//
// PARAMETERS
//   DATA_W   8   width of one channel word
//   SEL_W    2   slot index width; NUM_CH = 2**SEL_W (localparam), SEL_W >= 1
//
// PORTS
//   clk        in   1               single clock, rising edge
//   rst_n      in   1               asynchronous, active-low reset
//   in_valid   in   1               beat present on in_data this cycle
//   in_sof     in   1               start of frame; qualified by in_valid
//   in_data    in   DATA_W          beat payload
//   out_data   out  NUM_CH*DATA_W   channel words; ch i at [i*DATA_W +: DATA_W], registered
//   out_valid  out  NUM_CH          one-cycle pulse: channel i word updated this cycle
//   frame_done out  1               one-cycle pulse: last slot of a complete frame written
//   sync_err   out  1               one-cycle pulse: framing violation detected
//   locked     out  1               high while FSM is in RUN
//
// BEHAVIOUR
//   Reset (async assert, sync release)
//     - out_data=0, out_valid=0, frame_done=0, sync_err=0, locked=0.
//     - state=HUNT, slot=0.
//     - Reset asserted mid-frame abandons the frame immediately; no pulse is emitted.
//   Beat definition
//     - A beat occurs when in_valid=1.
//     - in_valid=0 cycles are idle: slot and state hold, all pulses low.
//     - Gaps of any length are legal inside a frame.
//   Latency
//     - All outputs are registered.
//     - A beat at edge N updates out_data and pulses out_valid, frame_done and sync_err in the cycle after edge N.
//     - out_data[ch] holds its value until that channel is written again.
//   FSM HUNT (locked=0)
//     - Beat with in_sof=1: write ch0, out_valid[0]=1, slot<=1, go to RUN.
//     - Beat with in_sof=0: dropped. No write, no sync_err.
//   FSM RUN (locked=1), beat at slot s
//     - in_sof=0, s!=0: write ch s, out_valid[s]=1.
//       If s==NUM_CH-1: frame_done=1 in the same cycle as out_valid[s], and slot wraps to 0. Otherwise slot<=s+1.
//     - in_sof=1, s==0: normal new frame. Write ch0, slot<=1.
//     - in_sof=1, s!=0 (early SOF): sync_err=1. The partial frame is abandoned with no frame_done.
//       The beat itself starts a new frame: write ch0, out_valid[0]=1, slot<=1. State stays RUN.
//     - in_sof=0, s==0 (missing SOF): sync_err=1. The beat is dropped; go to HUNT and set slot<=0.
//   Invariants
//     - At most one bit of out_valid is high in any cycle.
//     - frame_done implies out_valid[NUM_CH-1].
//     - sync_err and frame_done are never high together.
//     - Slot arithmetic is SEL_W bits wide; wrap from NUM_CH-1 to 0 is natural overflow.
//
// TESTING (DATA_W=8, SEL_W=2)
//   1. Reset, then beats {sof:A0},11,22,33 back-to-back
//      -> ch0..3 = A0,11,22,33.
//      -> out_valid = 0001,0010,0100,1000 on consecutive cycles.
//      -> frame_done with the 1000 pulse. locked=1 from the cycle after the first beat.
//   2. Two frames with 3 idle cycles inserted between slots 1 and 2
//      -> same data mapping; pulses stall during the gap.
//      -> frame_done once per frame; no sync_err.
//   3. In HUNT, beats 55,66 without sof, then {sof:77}
//      -> 55 and 66 are dropped (out_valid=0, locked=0).
//      -> 77 lands in ch0; locked=1.
//   4. {sof:01},02, then {sof:10},20,30,40
//      -> sync_err pulses on the {sof:10} beat; no frame_done for the first frame.
//      -> ch0..3 = 10,20,30,40, then frame_done.
//   5. A full frame, then a beat 99 without sof
//      -> sync_err=1, 99 not written, locked falls to 0.
//      -> A following {sof:AA} relocks with ch0=AA.
//   6. Assert rst_n=0 asynchronously mid-frame (slot 2)
//      -> all outputs 0 immediately, before the next clock edge.
//      -> After release, a beat without sof is dropped (HUNT).

Source files
------------

// File: rtl/tdm_demux.sv
// Receive side of a 2^SEL_W:1 TDM link: routes each framed beat to the output
// channel of its slot and flags framing violations.
module tdm_demux #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    input  logic                           in_sof,
    input  logic [DATA_W-1:0]              in_data,
    output logic [(2**SEL_W)*DATA_W-1:0]   out_data,
    output logic [(2**SEL_W)-1:0]          out_valid,
    output logic                           frame_done,
    output logic                           sync_err,
    output logic                           locked
);

    localparam int NUM_CH = 2**SEL_W;

    typedef enum logic [0:0] {
        ST_HUNT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                     state_r;
    state_t                     state_nxt_s;
    logic [SEL_W-1:0]           slot_r;
    logic [SEL_W-1:0]           slot_nxt_s;
    logic                       wr_en_s;
    logic [SEL_W-1:0]           wr_slot_s;
    logic                       done_s;
    logic                       err_s;
    logic [NUM_CH-1:0]          valid_nxt_s;

    logic [NUM_CH*DATA_W-1:0]   out_data_r;
    logic [NUM_CH-1:0]          out_valid_r;
    logic                       frame_done_r;
    logic                       sync_err_r;
    logic                       locked_r;

    // Next-state and per-beat write/pulse decisions.
    always_comb begin
        state_nxt_s = state_r;
        slot_nxt_s  = slot_r;
        wr_en_s     = 1'b0;
        wr_slot_s   = {SEL_W{1'b0}};
        done_s      = 1'b0;
        err_s       = 1'b0;
        case (state_r)
            ST_HUNT: begin
                if (in_valid && in_sof) begin
                    wr_en_s     = 1'b1;
                    wr_slot_s   = {SEL_W{1'b0}};
                    slot_nxt_s  = SEL_W'(1);
                    state_nxt_s = ST_RUN;
                end else begin
                    slot_nxt_s  = {SEL_W{1'b0}};
                end
            end
            ST_RUN: begin
                if (!in_valid) begin
                    slot_nxt_s = slot_r;
                end else if (in_sof) begin
                    // An SOF away from slot 0 abandons the partial frame but still opens a new one.
                    err_s      = (slot_r != {SEL_W{1'b0}});
                    wr_en_s    = 1'b1;
                    wr_slot_s  = {SEL_W{1'b0}};
                    slot_nxt_s = SEL_W'(1);
                end else if (slot_r == {SEL_W{1'b0}}) begin
                    err_s       = 1'b1;
                    slot_nxt_s  = {SEL_W{1'b0}};
                    state_nxt_s = ST_HUNT;
                end else begin
                    wr_en_s    = 1'b1;
                    wr_slot_s  = slot_r;
                    done_s     = (slot_r == {SEL_W{1'b1}});
                    slot_nxt_s = slot_r + SEL_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_HUNT;
                slot_nxt_s  = {SEL_W{1'b0}};
            end
        endcase
    end

    // One-hot strobe for the channel being written this beat.
    always_comb begin
        if (wr_en_s) begin
            valid_nxt_s = NUM_CH'(1) << wr_slot_s;
        end else begin
            valid_nxt_s = {NUM_CH{1'b0}};
        end
    end

    // Framing state and slot counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_HUNT;
            slot_r   <= {SEL_W{1'b0}};
            locked_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            slot_r   <= slot_nxt_s;
            locked_r <= (state_nxt_s == ST_RUN);
        end
    end

    // Registered channel words and pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r   <= {(NUM_CH*DATA_W){1'b0}};
            out_valid_r  <= {NUM_CH{1'b0}};
            frame_done_r <= 1'b0;
            sync_err_r   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_en_s && (wr_slot_s == SEL_W'(i))) begin
                    out_data_r[i*DATA_W +: DATA_W] <= in_data;
                end
            end
            out_valid_r  <= valid_nxt_s;
            frame_done_r <= done_s;
            sync_err_r   <= err_s;
        end
    end

    assign out_data   = out_data_r;
    assign out_valid  = out_valid_r;
    assign frame_done = frame_done_r;
    assign sync_err   = sync_err_r;
    assign locked     = locked_r;

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: directed framing scenarios plus random
// traffic, compared every cycle against a frame-level reference model.
module tb_tdm_demux;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 2;
    localparam int NUM_CH = 4;

    logic                       clk;
    logic                       rst_n;
    logic                       in_valid;
    logic                       in_sof;
    logic [DATA_W-1:0]          in_data;
    logic [NUM_CH*DATA_W-1:0]   out_data;
    logic [NUM_CH-1:0]          out_valid;
    logic                       frame_done;
    logic                       sync_err;
    logic                       locked;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    tdm_demux #(.DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_data    (in_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .frame_done (frame_done),
        .sync_err   (sync_err),
        .locked     (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: position within the current frame, or "not locked".
    bit         m_locked;
    int         m_pos;
    logic [7:0] m_ch [NUM_CH];
    logic [3:0] m_valid;
    bit         m_done;
    bit         m_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            m_valid = 4'b0000;
            m_done  = 1'b0;
            m_err   = 1'b0;
            if (!rst_n) begin
                m_locked = 1'b0;
                m_pos    = 0;
                for (int i = 0; i < NUM_CH; i++) m_ch[i] = 8'h00;
            end else if (in_valid) begin
                if (in_sof) begin
                    // Any SOF starts a frame; mid-frame it is a framing error.
                    m_err    = m_locked && (m_pos != 0);
                    m_ch[0]  = in_data;
                    m_valid  = 4'b0001;
                    m_pos    = 1;
                    m_locked = 1'b1;
                end else if (m_locked && m_pos == 0) begin
                    m_err    = 1'b1;
                    m_locked = 1'b0;
                end else if (m_locked) begin
                    m_ch[m_pos] = in_data;
                    m_valid     = 4'(1 << m_pos);
                    m_done      = (m_pos == NUM_CH - 1);
                    m_pos       = (m_pos + 1) % NUM_CH;
                end
            end
        end
    end

    // Per-cycle compare against the model plus structural invariants.
    initial begin
        logic [31:0] exp_data;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NUM_CH; i++) exp_data[i*8 +: 8] = m_ch[i];
            check("model_data",   64'(out_data),   64'(exp_data));
            check("model_valid",  64'(out_valid),  64'(m_valid));
            check("model_done",   64'(frame_done), 64'(m_done));
            check("model_err",    64'(sync_err),   64'(m_err));
            check("model_locked", 64'(locked),     64'(m_locked));
            check("inv_onehot",   64'($onehot0(out_valid)), 64'd1);
            check("inv_done_valid", 64'(!frame_done || out_valid[NUM_CH-1]), 64'd1);
            check("inv_err_done", 64'(!(frame_done && sync_err)), 64'd1);
            if (frame_done === 1'b1) done_cnt++;
            if (sync_err === 1'b1)   err_cnt++;
        end
    end

    task automatic step(input logic v, input logic s, input logic [7:0] d);
        @(negedge clk);
        in_valid = v;
        in_sof   = s;
        in_data  = d;
    endtask

    task automatic settle();
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
    endtask

    initial begin
        int d0, e0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = 8'h00;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data",   64'(out_data),  64'd0);
        check("rst_valid",  64'(out_valid), 64'd0);
        check("rst_locked", 64'(locked),    64'd0);
        rst_n = 1'b1;

        // 1: back-to-back frame
        step(1'b1, 1'b1, 8'hA0);
        settle();
        check("t1_first_valid", 64'(out_valid), 64'h1);
        check("t1_locked",      64'(locked),    64'h1);
        step(1'b1, 1'b0, 8'h11);
        step(1'b1, 1'b0, 8'h22);
        step(1'b1, 1'b0, 8'h33);
        settle();
        check("t1_data",  64'(out_data),   64'h3322_11A0);
        check("t1_valid", 64'(out_valid),  64'h8);
        check("t1_done",  64'(frame_done), 64'h1);

        // 2: two frames with a 3-cycle gap between slots 1 and 2
        d0 = done_cnt;
        e0 = err_cnt;
        for (int f = 0; f < 2; f++) begin
            step(1'b1, 1'b1, 8'hC0);
            step(1'b1, 1'b0, 8'hC1);
            repeat (3) step(1'b0, 1'b0, 8'hEE);
            step(1'b1, 1'b0, 8'hC2);
            step(1'b1, 1'b0, 8'hC3);
        end
        settle();
        check("t2_data",      64'(out_data),       64'hC3C2_C1C0);
        check("t2_done_cnt",  64'(done_cnt - d0),  64'd2);
        check("t2_err_cnt",   64'(err_cnt - e0),   64'd0);

        // 3: hunt drops beats without sof
        do_reset();
        step(1'b1, 1'b0, 8'h55);
        step(1'b1, 1'b0, 8'h66);
        settle();
        check("t3_drop_valid",  64'(out_valid), 64'h0);
        check("t3_drop_locked", 64'(locked),    64'h0);
        check("t3_drop_data",   64'(out_data),  64'h0);
        step(1'b1, 1'b1, 8'h77);
        settle();
        check("t3_ch0",    64'(out_data), 64'h0000_0077);
        check("t3_locked", 64'(locked),   64'h1);

        // 4: early sof
        do_reset();
        step(1'b1, 1'b1, 8'h01);
        step(1'b1, 1'b0, 8'h02);
        step(1'b1, 1'b1, 8'h10);
        settle();
        check("t4_err",   64'(sync_err),   64'h1);
        check("t4_valid", 64'(out_valid),  64'h1);
        step(1'b1, 1'b0, 8'h20);
        step(1'b1, 1'b0, 8'h30);
        step(1'b1, 1'b0, 8'h40);
        settle();
        check("t4_data", 64'(out_data),   64'h4030_2010);
        check("t4_done", 64'(frame_done), 64'h1);

        // 5: missing sof after a full frame
        step(1'b1, 1'b0, 8'h99);
        settle();
        check("t5_err",    64'(sync_err),  64'h1);
        check("t5_locked", 64'(locked),    64'h0);
        check("t5_valid",  64'(out_valid), 64'h0);
        check("t5_data",   64'(out_data),  64'h4030_2010);
        step(1'b1, 1'b1, 8'hAA);
        settle();
        check("t5_relock", 64'(out_data), 64'h4030_20AA);
        check("t5_locked2", 64'(locked),  64'h1);

        // 6: asynchronous reset mid-frame
        step(1'b1, 1'b0, 8'h11);
        step(1'b1, 1'b0, 8'h22);
        settle();
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_data",   64'(out_data),   64'h0);
        check("t6_async_valid",  64'(out_valid),  64'h0);
        check("t6_async_locked", 64'(locked),     64'h0);
        check("t6_async_pulses", 64'({frame_done, sync_err}), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 8'h5A);
        settle();
        check("t6_hunt_valid",  64'(out_valid), 64'h0);
        check("t6_hunt_locked", 64'(locked),    64'h0);

        // Random traffic with occasional asynchronous resets
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 199));
            if (r < 2) begin
                @(negedge clk);
                in_valid = 1'b0;
                #2 rst_n = 1'b0;
                #1 check("rnd_async_valid", 64'(out_valid), 64'h0);
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                step(1'($urandom_range(0, 9) < 7),
                     1'($urandom_range(0, 9) < 2),
                     8'($urandom));
            end
        end
        settle();
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
